// File: rtl/dwt_pkg.sv
// Shared constants and types for the 2-D DWT block sequencer.
// Defines the block geometry and the input-side FSM state type.
package dwt_pkg;

  localparam int ROWS      = 8;
  localparam int ROW_W     = 64;
  localparam int PIX_W     = 8;
  localparam int BLK_W     = ROWS * ROW_W;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef enum logic {
    FILL,
    COMPUTE
  } dwt_seq_state_t;

endpackage

// File: rtl/dwt_row_buf.sv
// 8 x 64-bit register file with indexed row write, full-block load and flat read.
// Row k of the flat view occupies bits [64k+63:64k].
module dwt_row_buf
  import dwt_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ROW_IDX_W-1:0] wr_idx,
  input  logic [ROW_W-1:0]     wr_row,
  input  logic                 load_en,
  input  logic [BLK_W-1:0]     load_blk,
  output logic [BLK_W-1:0]     rd_blk
);

  logic [ROWS-1:0][ROW_W-1:0] mem;

  // NOTE: this buffer is cleared on reset because its contents are visible on
  // dwt_inp/out_row; a plain storage RAM would normally be left unreset.
  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (load_en) begin
      mem <= load_blk;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_row;
    end
  end

  assign rd_blk = mem;

endmodule

// File: rtl/dwt_block_sequencer.sv
// Assembles 8 pixel rows into a block for the DWT, waits its latency, captures
// the coefficient block and streams it out; fill and drain overlap.
module dwt_block_sequencer
  import dwt_pkg::*;
#(
  parameter int DWT_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROW_W-1:0] in_row,
  output logic [BLK_W-1:0] dwt_inp,
  input  logic [BLK_W-1:0] dwt_outp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic             out_first,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] block_count
);

  localparam int                        WAIT_W   = 4;
  localparam logic [WAIT_W-1:0]         LAT      = WAIT_W'(DWT_LATENCY);
  localparam logic [ROW_IDX_W-1:0]      LAST_ROW = ROW_IDX_W'(ROWS - 1);

  dwt_seq_state_t       state;
  logic [ROW_IDX_W-1:0] row_cnt;
  logic [ROW_IDX_W-1:0] out_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 obuf_full;
  logic [BLK_W-1:0]     ibuf_blk;
  logic [BLK_W-1:0]     obuf_blk;
  logic                 in_fire;
  logic                 out_fire;
  logic                 wait_done;
  logic                 capture;

  assign in_ready  = !rst && (state == FILL);
  assign out_valid = !rst && obuf_full;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wait_done = (wait_cnt == LAT);
  // Capture only into an empty obuf as seen at the start of the cycle, so the
  // final drain handshake and the next capture never share an edge.
  assign capture   = !rst && (state == COMPUTE) && wait_done && !obuf_full;

  dwt_row_buf u_ibuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (in_fire),
    .wr_idx   (row_cnt),
    .wr_row   (in_row),
    .load_en  (1'b0),
    .load_blk ('0),
    .rd_blk   (ibuf_blk)
  );

  dwt_row_buf u_obuf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (1'b0),
    .wr_idx   ('0),
    .wr_row   ('0),
    .load_en  (capture),
    .load_blk (dwt_outp),
    .rd_blk   (obuf_blk)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      row_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == LAST_ROW) begin
              state    <= COMPUTE;
              wait_cnt <= '0;
            end
          end
        end
        COMPUTE: begin
          if (capture) begin
            state   <= FILL;
            row_cnt <= '0;
          end else if (!wait_done) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obuf_full   <= 1'b0;
      out_cnt     <= '0;
      block_count <= '0;
    end else if (capture) begin
      obuf_full <= 1'b1;
    end else if (out_fire) begin
      if (out_cnt == LAST_ROW) begin
        obuf_full   <= 1'b0;
        out_cnt     <= '0;
        block_count <= block_count + CNT_W'(1);
      end else begin
        out_cnt <= out_cnt + 1'b1;
      end
    end
  end

  assign dwt_inp   = rst ? '0 : ibuf_blk;
  assign out_row   = out_valid ? obuf_blk[{out_cnt, 6'd0} +: ROW_W] : '0;
  assign out_first = out_valid && (out_cnt == '0);
  assign out_last  = out_valid && (out_cnt == LAST_ROW);
  assign busy      = !rst && ((state == COMPUTE) || (row_cnt != '0) || obuf_full);

endmodule

// File: doc/dwt_block_sequencer.md
# dwt_block_sequencer

Sequences the 2-D DWT datapath: assembles an incoming stream of 64-bit pixel rows (8 × 8-bit pixels) into an 8×8 block and presents it on the DWT's eight 64-bit row inputs. It then waits the DWT pipeline latency, captures the eight 64-bit coefficient rows and streams them out with a valid/ready handshake. Input and output buffers are separate, so the next block fills while the previous one drains. It sits between the pixel source and the coefficient sink, wrapping the DWT instance.

## Interface

- DWT_LATENCY, 1, clock edges from stable DWT inputs to valid DWT outputs (0..15)
- CNT_W, 16, width of block_count

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  source row valid
- in_ready  out  1  sequencer accepts row
- in_row  in  64  pixel row, pixel 0 in [63:56]
- dwt_inp  out  512  rows to DWT; row k on [64k+63:64k] → DWT inp(k+1)
- dwt_outp  in  512  DWT rows; outp(k+1) on [64k+63:64k]
- out_valid  out  1  coefficient row valid
- out_ready  in  1  sink accepts row
- out_row  out  64  coefficient row
- out_first  out  1  out_row is row 0 of block
- out_last  out  1  out_row is row 7 of block
- busy  out  1  any block in flight
- block_count  out  CNT_W  blocks fully drained, wraps modulo 2^CNT_W

## Operation

- Input FSM states: FILL, COMPUTE. Output side: flag obuf_full.
- FILL: in_ready = 1. Each handshake (in_valid & in_ready) writes in_row to ibuf[row_cnt] and increments row_cnt (3 bits). Handshake with row_cnt = 7 → COMPUTE, wait_cnt = 0.
- dwt_inp is driven directly from ibuf. It is constant throughout COMPUTE because in_ready = 0.
- COMPUTE: wait_cnt increments each cycle and saturates at DWT_LATENCY. Capture happens on the edge where wait_cnt = DWT_LATENCY and obuf_full = 0 at the start of the cycle: obuf ← dwt_outp, obuf_full ← 1, state → FILL, row_cnt = 0.
- If obuf_full = 1, COMPUTE holds. There is no same-cycle capture with the final drain handshake; this costs exactly one bubble.
- Output: out_valid = obuf_full, out_row = obuf[out_cnt], out_first = obuf_full & (out_cnt = 0), out_last = obuf_full & (out_cnt = 7).
- Each output handshake increments out_cnt. On the handshake with out_cnt = 7: obuf_full ← 0, out_cnt ← 0, block_count increments (wraps).
- busy = (state = COMPUTE) | (row_cnt ≠ 0) | obuf_full.
- in_row and dwt_outp are passed bit-exact; no arithmetic on data.

## Timing

- On reset (takes effect at the edge where rst is sampled high): state = FILL, row_cnt = out_cnt = wait_cnt = 0, ibuf = obuf = 0, obuf_full = 0, block_count = 0.
- While rst is high: in_ready = 0, out_valid = 0, out_row = 0, out_first = out_last = 0, busy = 0, dwt_inp = 0.
- rst mid-block discards partial input rows and any undrained output. The first handshake after rst deasserts is row 0 of a new block.
- Latency: the 8th input handshake is at edge E. Capture is at edge E + DWT_LATENCY + 1 (with obuf empty). out_valid is high in the cycle after capture.
- out_row, out_first and out_last hold stable while out_valid & !out_ready.
- in_ready is combinational from state and rst only, never from in_valid.
- Steady-state throughput with continuous valid/ready: one block per max(8, 8 + DWT_LATENCY + 1 − 8 + 8) cycles. Both sides overlap.

## Structure

- Shared package dwt_pkg holds:
  - ROWS = 8, ROW_W = 64, PIX_W = 8, BLK_W = ROWS*ROW_W
  - typedef enum {FILL, COMPUTE} dwt_seq_state_t
- Sub-module dwt_row_buf: 8 × 64 register file with an indexed single-row write, a full-block parallel load, flat 512-bit read and synchronous reset. It is instantiated twice (ibuf with row write, obuf with block load).
- The top-level integration instantiates dwt_block_sequencer and DWT side by side; the DWT itself is unchanged.

## Test plan

- Single block, DWT_LATENCY = 1, out_ready = 1, stub DWT (outputs = inputs delayed 1 edge). Rows 20302C620262C616, 20302C620262C616, 1602026202020202, 202620262026201A, 812026201A201A20, 1922026201A7A201, 192201A201A201A2, 192201E201A201A1 → dwt_inp matches row order; out_valid rises 2 edges after the 8th handshake; 8 rows out identical and in order; out_first on row 0 only, out_last on row 7 only; block_count = 1.
- out_ready toggling 1,0,1,0… → all 8 rows emitted in order, out_row stable during stalls, no duplicate or skipped row.
- out_ready = 0 while 2 further blocks are offered → block 2 fills and holds in COMPUTE with in_ready = 0. Release out_ready → block 1 drains, block 2 captured one cycle later, block 3 then accepted; no row lost.
- rst held 3 cycles after 4 rows of a block loaded and 3 rows of the previous block drained → all outputs 0 during reset, busy = 0. Next 8 rows form a clean block, block_count restarts at 0.
- Random in_valid gaps (≈50%) → rows land in ibuf by handshake count, not cycle count.
- CNT_W = 2, 5 consecutive blocks → block_count sequence 1, 2, 3, 0, 1.
